// File: rtl/hex_display_scheduler.sv
// Six-digit seven-segment display owner: round-robin write port for two clients,
// one shared decoder scanned across the displays, per-digit blank/blink masks.
module hex_display_scheduler #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [2:0]            sel_a,
  input  logic [3:0]            val_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic [2:0]            sel_b,
  input  logic [3:0]            val_b,
  output logic                  ack_b,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5,
  output logic                  frame_done
);

  localparam int              CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]   BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]      NUM_SEL    = 3'(NUM_DIGITS);
  localparam logic [6:0]      SEG_DARK   = 7'h7F;

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0][6:0] hex_q, hex_d;
  logic [2:0]                 idx_q, idx_d;
  logic [CW-1:0]              blink_cnt_q, blink_cnt_d;
  logic                       blink_off_q, blink_off_d;
  logic                       last_grant_b_q, last_grant_b_d;
  logic                       ack_a_q, ack_a_d;
  logic                       ack_b_q, ack_b_d;
  logic                       frame_done_q, frame_done_d;

  logic                       elig_a, elig_b;
  logic                       grant_a, grant_b;
  logic                       wr_en;
  logic [2:0]                 wr_sel;
  logic [3:0]                 wr_val;
  logic [3:0]                 dec_in;
  logic [6:0]                 dec_out;
  logic                       dark;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A requester still seeing its ack is ineligible, so a held request writes once.
  always_comb begin
    elig_a         = req_a & ~ack_a_q;
    elig_b         = req_b & ~ack_b_q;
    grant_a        = elig_a & (~elig_b | last_grant_b_q);
    grant_b        = elig_b & ~grant_a;
    wr_en          = grant_a | grant_b;
    wr_sel         = grant_a ? sel_a : sel_b;
    wr_val         = grant_a ? val_a : val_b;
    ack_a_d        = grant_a;
    ack_b_d        = grant_b;
    last_grant_b_d = last_grant_b_q;
    if (wr_en) begin
      last_grant_b_d = grant_b;
    end
  end

  always_comb begin
    digit_d = digit_q;
    if (wr_en && (wr_sel < NUM_SEL)) begin
      digit_d[wr_sel] = wr_val;
    end
  end

  // Scanner reads the pre-write digit, so a same-cycle write shows on the next pass.
  always_comb begin
    idx_d        = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    dec_in       = digit_q[idx_q];
    dec_out      = seg7(dec_in);
    dark         = blank_mask[idx_q] | (blink_mask[idx_q] & blink_off_q);
    hex_d        = hex_q;
    hex_d[idx_q] = dark ? SEG_DARK : dec_out;
    frame_done_d = (idx_q == IDX_LAST);
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_off_d = blink_off_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q        <= '0;
      hex_q          <= {NUM_DIGITS{SEG_DARK}};
      idx_q          <= 3'd0;
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      last_grant_b_q <= 1'b1;
      ack_a_q        <= 1'b0;
      ack_b_q        <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      digit_q        <= digit_d;
      hex_q          <= hex_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_off_q    <= blink_off_d;
      last_grant_b_q <= last_grant_b_d;
      ack_a_q        <= ack_a_d;
      ack_b_q        <= ack_b_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign frame_done = frame_done_q;
  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign hex4       = hex_q[4];
  assign hex5       = hex_q[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: decoder vector table, hand sequences for
// reset/contention/blank/blink/async reset, then random traffic against a model.
module tb_hex_display_scheduler;

  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] sel_a = '0, sel_b = '0;
  logic [3:0] val_a = '0, val_b = '0;
  logic       ack_a, ack_b, frame_done;
  logic [5:0] blank_mask = '0, blink_mask = '0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0] hx [6];

  int total = 0;
  int bad   = 0;

  hex_display_scheduler #(.NUM_DIGITS(6), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .sel_a(sel_a), .val_a(val_a), .ack_a(ack_a),
    .req_b(req_b), .sel_b(sel_b), .val_b(val_b), .ack_b(ack_b),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: scan slot and blink phase follow directly from cycles since reset.
  int         m_t;
  logic [3:0] m_dig [6];
  logic [6:0] m_hex [6];
  bit         m_ack_a, m_ack_b, m_last_b, m_fd;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] val;
    logic [5:0] blank;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 6; i++) chk($sformatf("model hex%0d", i), hx[i], m_hex[i]);
    chk("model ack_a", {6'd0, ack_a}, {6'd0, m_ack_a});
    chk("model ack_b", {6'd0, ack_b}, {6'd0, m_ack_b});
    chk("model frame_done", {6'd0, frame_done}, {6'd0, m_fd});
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 6; i++) begin
      m_dig[i] = 4'h0;
      m_hex[i] = 7'h7F;
    end
    m_ack_a = 0; m_ack_b = 0; m_last_b = 1; m_fd = 0;
  endtask

  task automatic tick();
    int ix, boff;
    bit ea, eb, ga, gb;
    ix   = m_t % 6;
    boff = (m_t / BDIV) % 2;
    if (blank_mask[ix] || (blink_mask[ix] && boff == 1)) m_hex[ix] = 7'h7F;
    else m_hex[ix] = seg_ref[m_dig[ix]];
    ea = req_a && !m_ack_a;
    eb = req_b && !m_ack_b;
    ga = ea && (!eb || m_last_b);
    gb = eb && !ga;
    if (ga || gb) m_last_b = gb;
    if (ga && sel_a < 6) m_dig[sel_a] = val_a;
    if (gb && sel_b < 6) m_dig[sel_b] = val_b;
    m_ack_a = ga;
    m_ack_b = gb;
    m_fd    = (ix == 5);
    m_t++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = 0; req_b = 0; blank_mask = '0; blink_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) chk($sformatf("reset hex%0d", i), hx[i], 7'h7F);
    chk("reset ack_a", {6'd0, ack_a}, 7'd0);
    chk("reset ack_b", {6'd0, ack_b}, 7'd0);
    chk("reset frame_done", {6'd0, frame_done}, 7'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 4'h0, 6'b000000, 7'h40};
    vecs[1]  = '{3'd1, 4'h1, 6'b000000, 7'h79};
    vecs[2]  = '{3'd2, 4'h2, 6'b000000, 7'h24};
    vecs[3]  = '{3'd3, 4'h3, 6'b000000, 7'h30};
    vecs[4]  = '{3'd4, 4'h4, 6'b000000, 7'h19};
    vecs[5]  = '{3'd5, 4'h5, 6'b000000, 7'h12};
    vecs[6]  = '{3'd0, 4'h6, 6'b000000, 7'h02};
    vecs[7]  = '{3'd1, 4'h7, 6'b000000, 7'h78};
    vecs[8]  = '{3'd2, 4'h8, 6'b000000, 7'h00};
    vecs[9]  = '{3'd3, 4'h9, 6'b000000, 7'h10};
    vecs[10] = '{3'd4, 4'hA, 6'b000000, 7'h08};
    vecs[11] = '{3'd5, 4'hB, 6'b000000, 7'h03};
    vecs[12] = '{3'd0, 4'hC, 6'b000000, 7'h46};
    vecs[13] = '{3'd1, 4'hD, 6'b000000, 7'h21};
    vecs[14] = '{3'd2, 4'hE, 6'b000000, 7'h06};
    vecs[15] = '{3'd3, 4'hF, 6'b000000, 7'h0E};
    vecs[16] = '{3'd4, 4'h7, 6'b010000, 7'h7F};
    vecs[17] = '{3'd2, 4'hA, 6'b000000, 7'h08};

    // Power-up scan: HEXi lights in cycle i+1, frame_done every sixth cycle.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      tick();
      for (int i = 0; i < 6; i++)
        chk($sformatf("idle c%0d hex%0d", c, i), hx[i], (i < c) ? 7'h40 : 7'h7F);
      chk($sformatf("idle c%0d frame_done", c), {6'd0, frame_done}, {6'd0, (c % 6 == 0)});
    end

    // Decoder table through requester A.
    foreach (vecs[k]) begin
      req_a = 1; sel_a = vecs[k].sel; val_a = vecs[k].val; blank_mask = vecs[k].blank;
      tick();
      chk($sformatf("vec%0d ack_a", k), {6'd0, ack_a}, 7'd1);
      req_a = 0;
      repeat (7) tick();
      chk($sformatf("vec%0d hex", k), hx[vecs[k].sel], vecs[k].exp);
    end
    blank_mask = '0;

    // Contention: grants alternate starting with A.
    do_reset();
    req_a = 1; sel_a = 3'd0; val_a = 4'h3;
    req_b = 1; sel_b = 3'd1; val_b = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr%0d ack_a", k), {6'd0, ack_a}, {6'd0, (k % 2 == 0)});
      chk($sformatf("rr%0d ack_b", k), {6'd0, ack_b}, {6'd0, (k % 2 == 1)});
    end
    req_a = 0; req_b = 0;
    repeat (7) tick();
    chk("rr hex0", hex0, 7'h30);
    chk("rr hex1", hex1, 7'h0E);

    // Out-of-range select is acked but writes nothing; A then served.
    req_b = 1; sel_b = 3'd7; val_b = 4'h5;
    tick();
    chk("sel7 ack_b", {6'd0, ack_b}, 7'd1);
    req_b = 0;
    req_a = 1; sel_a = 3'd4; val_a = 4'h5;
    tick();
    chk("after sel7 ack_a", {6'd0, ack_a}, 7'd1);
    req_a = 0;
    repeat (7) tick();
    chk("sel7 hex0", hex0, 7'h30);
    chk("sel7 hex1", hex1, 7'h0E);
    chk("sel7 hex2", hex2, 7'h40);
    chk("sel7 hex3", hex3, 7'h40);
    chk("sel7 hex4", hex4, 7'h12);
    chk("sel7 hex5", hex5, 7'h40);

    // Blank mask on digit 0.
    req_a = 1; sel_a = 3'd0; val_a = 4'h8;
    tick();
    req_a = 0;
    repeat (7) tick();
    chk("blank pre hex0", hex0, 7'h00);
    blank_mask = 6'b000001;
    repeat (6) tick();
    chk("blank on hex0", hex0, 7'h7F);
    blank_mask = 6'b000000;
    repeat (6) tick();
    chk("blank off hex0", hex0, 7'h00);

    // Blink on digit 5 with a 4-cycle half period.
    do_reset();
    blink_mask = 6'b100000;
    req_a = 1; sel_a = 3'd5; val_a = 4'h1;
    tick();
    req_a = 0;
    for (int c = 2; c <= 36; c++) begin
      tick();
      if (c == 6)  chk("blink c6 hex5", hex5, 7'h7F);
      if (c == 12) chk("blink c12 hex5", hex5, 7'h79);
      if (c == 24) chk("blink c24 hex5", hex5, 7'h7F);
      if (c == 36) chk("blink c36 hex5", hex5, 7'h79);
    end
    req_b = 1; sel_b = 3'd0; val_b = 4'h2;
    tick();
    chk("pre-reset ack_b", {6'd0, ack_b}, 7'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("async reset hex%0d", i), hx[i], 7'h7F);
    chk("async reset ack_b", {6'd0, ack_b}, 7'd0);
    chk("async reset frame_done", {6'd0, frame_done}, 7'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (req_a && m_ack_a) req_a = 0;
      if (!req_a && ($urandom % 3 == 0)) begin
        req_a = 1; sel_a = 3'($urandom % 8); val_a = 4'($urandom % 16);
      end
      if (req_b && m_ack_b) req_b = 0;
      if (!req_b && ($urandom % 3 == 0)) begin
        req_b = 1; sel_b = 3'($urandom % 8); val_b = 4'($urandom % 16);
      end
      if ($urandom % 16 == 0) blank_mask = 6'($urandom % 64);
      if ($urandom % 16 == 0) blink_mask = 6'($urandom % 64);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
